branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer for the 5-stage pipeline: answers the IF-stage prediction lookup for the next-PC mux and consumes the EX-stage resolution commands (`upd_cmd_e`: allocate/correct or invalidate) issued by the branch-resolution judge. It owns prediction storage, optional 2-bit direction counters and two performance counters. It is the receiving end of the judge's BTB-update encoding.

## Interface
- `INDEX_W`, 6, index width; table depth 2^INDEX_W; index = pc[INDEX_W+1:2], tag = pc[31:INDEX_W+2]
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `pc_f` in 32: IF-stage PC to look up
- `pred_taken_f` out 1: predict taken
- `pred_target_f` out 32: predicted next PC (stored target if predicted taken, else `pc_f+4`)
- `upd_cmd_e` in 2: 2'b00 none, 2'b10 actually taken but mispredicted (write), 2'b01 actually not taken but mispredicted (invalidate/weaken), 2'b11 illegal
- `upd_pc_e` in 32: PC of the resolving branch in EX
- `upd_target_e` in 32: resolved branch target in EX
- `br_valid_e` in 1: EX holds a branch instruction
- `br_taken_e` in 1: EX branch resolved taken
- `br_cnt` out 32: resolved-branch count
- `miss_cnt` out 32: mispredict count

## Operation
- Entry contents: valid, tag (32-2-INDEX_W bits), target (32 bits), plus a 2-bit counter under `BTB_BHT_EN`.
- Hit: `valid[idx] && tag[idx]==pc_f tag`.
- Without BHT: `pred_taken_f = hit`.
- With BHT: `pred_taken_f = hit && ctr[1]`.
- Cmd 2'b10: on a tag hit, overwrite the target; on a tag miss, replace the entry (valid=1, new tag, new target).
  - BHT: a hit increments ctr with saturation at 2'b11; an allocation sets ctr=2'b10.
- Cmd 2'b01 on a tag hit:
  - Without BHT: clear valid.
  - With BHT: decrement ctr with saturation at 2'b00; the entry stays valid.
- Cmd 2'b01 on a tag miss: no-op.
- Cmd 2'b00 with `br_valid_e` on a tag hit: BHT only, train ctr toward `br_taken_e` (saturating). Without BHT this is a no-op.
- Cmd 2'b11: no table change and not counted.
- `br_cnt` increments on `br_valid_e`.
- `miss_cnt` increments on cmd 2'b10 or 2'b01.
- Both counters wrap modulo 2^32.

## Timing
- Lookup is combinational, zero latency from `pc_f`.
- Updates and counters are registered and become visible after the next rising edge.
- Same-cycle update and lookup of the same index: the lookup returns pre-update contents (read-before-write).
- Reset: all valid bits, ctrs and both counters clear asynchronously.
  - While `rst_n`=0, `pred_taken_f`=0 and `pred_target_f`=`pc_f+4`.
  - `br_cnt`=`miss_cnt`=0 while reset is asserted.
- Reset asserted mid-update: the update is lost. The first edge after release performs normal operation.
- Targets are stored full 32-bit; no compression. `pc_f+4` wraps modulo 2^32.

## Configuration
- `BTB_BHT_EN` defined: adds per-entry 2-bit saturating direction counters.
  - Prediction needs a hit with ctr[1]=1.
  - Cmd 01 weakens the counter instead of invalidating the entry.
  - Correct predictions with cmd 00 train the counter.
- `BTB_BHT_EN` undefined: no counter storage; a hit alone means taken; cmd 01 invalidates; `br_taken_e` is unused.

## Structure
- Package `btb_pkg`:
  - cmd encodings `BTB_CMD_NONE`/`BTB_CMD_TAKEN_MISS`/`BTB_CMD_NTAKEN_MISS`
  - ctr constants `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`
  - entry struct typedef
  - index/tag slicing functions
- One sub-module `sat_ctr2` (2-bit saturating up/down next-state), instantiated only under `BTB_BHT_EN`.

## Test plan
Values assume INDEX_W=6, so 0x1004 maps to idx 1, tag 0x10.

- Release reset, `pc_f`=0x1004 -> `pred_taken_f`=0, `pred_target_f`=0x1008, both counters 0.
- Cmd 10, `upd_pc_e`=0x1004, `upd_target_e`=0x2000, `br_valid_e`=1 -> after the edge, `pc_f`=0x1004 gives taken with target 0x2000 (both configs); `br_cnt`=1, `miss_cnt`=1.
- After the previous scenario, `pc_f`=0x1104 (idx 1, tag 0x11) -> not taken, target 0x1108.
- Cmd 01 on 0x1004:
  - Without BHT: the next lookup is not taken.
  - With BHT: ctr 10->01, the lookup is not taken; a following cmd 00 with `br_taken_e`=1 gives ctr 10 and a taken prediction to 0x2000.
- Cmd 10 on 0x1004 with target 0x3000 while `pc_f`=0x1004 -> that cycle gives 0x2000, the next cycle gives 0x3000.
- Assert `rst_n`=0 between edges after traffic -> `pred_taken_f`=0 immediately, both counters 0, and a lookup of 0x1004 after release misses.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types, command/counter encodings and PC slicing helpers for the branch target buffer.
// Entry layout depends on the BTB_BHT_EN macro (direction counter present only when defined).
package btb_pkg;

  typedef enum logic [1:0] {
    BTB_CMD_NONE        = 2'b00,
    BTB_CMD_NTAKEN_MISS = 2'b01,
    BTB_CMD_TAKEN_MISS  = 2'b10,
    BTB_CMD_ILLEGAL     = 2'b11
  } btb_cmd_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tags are held at the widest possible size; narrower configs keep the upper bits zero.
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
`ifdef BTB_BHT_EN
    logic [1:0]           ctr;
`endif
  } btb_entry_t;

  function automatic logic [31:0] btb_index(input logic [31:0] pc, input int index_w);
    return (pc >> 2) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [TAG_MAX_W-1:0] btb_tag(input logic [31:0] pc, input int index_w);
    return TAG_MAX_W'(pc >> (index_w + 2));
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// IF-stage lookup, EX-stage resolution and performance-counter signals of the branch target buffer.
interface btb_if;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic [1:0]  upd_cmd_e;
  logic [31:0] upd_pc_e;
  logic [31:0] upd_target_e;
  logic        br_valid_e;
  logic        br_taken_e;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output pc_f, upd_cmd_e, upd_pc_e, upd_target_e, br_valid_e, br_taken_e,
    input  pred_taken_f, pred_target_f, br_cnt, miss_cnt
  );

  modport slave (
    input  pc_f, upd_cmd_e, upd_pc_e, upd_target_e, br_valid_e, br_taken_e,
    output pred_taken_f, pred_target_f, br_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_target_buffer_sat_ctr2.sv
// Next-state of a 2-bit saturating up/down direction counter (used only when BTB_BHT_EN is defined).
module sat_ctr2
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nxt
);

  // Step toward the requested direction, holding at either end.
  always_comb begin
    nxt = ctr;
    if (up) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational IF lookup, registered EX updates, perf counters.
// Optional per-entry 2-bit direction counters are built when the BTB_BHT_EN macro is defined.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int INDEX_W = 6
) (
  input logic   clk,
  input logic   rst_n,
  btb_if.slave  bus
);

  localparam int DEPTH = 1 << INDEX_W;

  btb_entry_t           tbl_r [DEPTH];
  logic [31:0]          br_cnt_r;
  logic [31:0]          miss_cnt_r;

  logic [31:0]          lk_raw_s;
  logic [31:0]          up_raw_s;
  logic [INDEX_W-1:0]   lk_idx_s;
  logic [INDEX_W-1:0]   up_idx_s;
  logic [TAG_MAX_W-1:0] lk_tag_s;
  logic [TAG_MAX_W-1:0] up_tag_s;
  btb_entry_t           lk_ent_s;
  btb_entry_t           up_ent_s;
  btb_entry_t           nxt_ent_s;
  logic                 lk_hit_s;
  logic                 up_hit_s;
  logic                 taken_s;
  logic                 we_s;
  logic                 unused_s;

`ifdef BTB_BHT_EN
  logic                 ctr_up_s;
  logic [1:0]           ctr_nxt_s;

  // Cmd 10 and correct-taken training count up; everything else weakens.
  always_comb begin
    ctr_up_s = (bus.upd_cmd_e == BTB_CMD_TAKEN_MISS) ||
               ((bus.upd_cmd_e == BTB_CMD_NONE) && bus.br_taken_e);
  end

  sat_ctr2 u_sat_ctr2 (
    .ctr (up_ent_s.ctr),
    .up  (ctr_up_s),
    .nxt (ctr_nxt_s)
  );
`endif

  assign unused_s = ^{lk_raw_s[31:INDEX_W], up_raw_s[31:INDEX_W]
`ifndef BTB_BHT_EN
                      , bus.br_taken_e
`endif
                     };

  // IF lookup reads pre-update contents, giving read-before-write on a shared index.
  always_comb begin
    lk_raw_s = btb_index(bus.pc_f, INDEX_W);
    lk_idx_s = lk_raw_s[INDEX_W-1:0];
    lk_tag_s = btb_tag(bus.pc_f, INDEX_W);
    lk_ent_s = tbl_r[lk_idx_s];
    lk_hit_s = lk_ent_s.valid && (lk_ent_s.tag == lk_tag_s);
`ifdef BTB_BHT_EN
    taken_s  = lk_hit_s && lk_ent_s.ctr[1];
`else
    taken_s  = lk_hit_s;
`endif
    bus.pred_taken_f  = taken_s;
    bus.pred_target_f = taken_s ? lk_ent_s.target : bus.pc_f + 32'd4;
  end

  // Locate the entry addressed by the resolving branch.
  always_comb begin
    up_raw_s = btb_index(bus.upd_pc_e, INDEX_W);
    up_idx_s = up_raw_s[INDEX_W-1:0];
    up_tag_s = btb_tag(bus.upd_pc_e, INDEX_W);
    up_ent_s = tbl_r[up_idx_s];
    up_hit_s = up_ent_s.valid && (up_ent_s.tag == up_tag_s);
  end

  // Decide the new entry contents and whether it gets written this cycle.
  always_comb begin
    nxt_ent_s = up_ent_s;
    we_s      = 1'b0;
    case (bus.upd_cmd_e)
      BTB_CMD_TAKEN_MISS: begin
        we_s             = 1'b1;
        nxt_ent_s.valid  = 1'b1;
        nxt_ent_s.tag    = up_tag_s;
        nxt_ent_s.target = bus.upd_target_e;
`ifdef BTB_BHT_EN
        nxt_ent_s.ctr    = up_hit_s ? ctr_nxt_s : CTR_WT;
`endif
      end
      BTB_CMD_NTAKEN_MISS: begin
        if (up_hit_s) begin
          we_s = 1'b1;
`ifdef BTB_BHT_EN
          nxt_ent_s.ctr   = ctr_nxt_s;
`else
          nxt_ent_s.valid = 1'b0;
`endif
        end else begin
          we_s = 1'b0;
        end
      end
      BTB_CMD_NONE: begin
`ifdef BTB_BHT_EN
        if (bus.br_valid_e && up_hit_s) begin
          we_s          = 1'b1;
          nxt_ent_s.ctr = ctr_nxt_s;
        end else begin
          we_s = 1'b0;
        end
`else
        we_s = 1'b0;
`endif
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Prediction table storage; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_r[i] <= '0;
      end
    end else if (we_s) begin
      tbl_r[up_idx_s] <= nxt_ent_s;
    end
  end

  // Resolved-branch and mispredict counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_r   <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (bus.br_valid_e) begin
        br_cnt_r <= br_cnt_r + 32'd1;
      end
      if ((bus.upd_cmd_e == BTB_CMD_TAKEN_MISS) || (bus.upd_cmd_e == BTB_CMD_NTAKEN_MISS)) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign bus.br_cnt   = br_cnt_r;
  assign bus.miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed scenarios plus random traffic against a
// reference model of the table rules; honours BTB_BHT_EN like the design.
module tb_branch_target_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  btb_if bus();

  branch_target_buffer #(.INDEX_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] br;
    logic [31:0] miss;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per table slot, plus the two counters.
  bit          m_valid  [64];
  logic [31:0] m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  logic [31:0] m_br;
  logic [31:0] m_miss;

  logic        l_rst;
  logic [1:0]  l_cmd;
  logic [31:0] l_upc;
  logic [31:0] l_tgt;
  logic        l_bv;
  logic        l_bt;

`ifdef BTB_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_br   = 32'd0;
    m_miss = 32'd0;
  endfunction

  function automatic void model_update(logic [1:0] cmd, logic [31:0] upc, logic [31:0] tgt,
                                       logic bv, logic bt);
    int          i;
    logic [31:0] t;
    bit          hit;
    i   = int'((upc / 32'd4) % 32'd64);
    t   = upc / 32'd256;
    hit = m_valid[i] && (m_tag[i] == t);
    if (bv) m_br = m_br + 32'd1;
    if (cmd == 2'b10 || cmd == 2'b01) m_miss = m_miss + 32'd1;
    if (cmd == 2'b10) begin
      if (hit) begin
        m_target[i] = tgt;
        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      end else begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = t;
        m_target[i] = tgt;
        m_ctr[i]    = 2;
      end
    end else if (cmd == 2'b01 && hit) begin
      if (BHT) m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      else     m_valid[i] = 1'b0;
    end else if (cmd == 2'b00 && bv && hit && BHT) begin
      if (bt) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      else    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end
  endfunction

  function automatic exp_t model_lookup(logic [31:0] pc, string name);
    exp_t e;
    int   i;
    bit   hit;
    i   = int'((pc / 32'd4) % 32'd64);
    hit = m_valid[i] && (m_tag[i] == pc / 32'd256);
    e.taken  = hit && (!BHT || m_ctr[i] >= 2);
    e.target = e.taken ? m_target[i] : pc + 32'd4;
    e.br     = m_br;
    e.miss   = m_miss;
    e.name   = name;
    return e;
  endfunction

  // One pipeline cycle: the edge commits last cycle's update, then new inputs are applied.
  task automatic cycle(string name, logic r, logic [31:0] pc, logic [1:0] cmd,
                       logic [31:0] upc, logic [31:0] tgt, logic bv, logic bt);
    @(posedge clk);
    if (l_rst) model_update(l_cmd, l_upc, l_tgt, l_bv, l_bt);
    #1;
    rst_n            = r;
    bus.pc_f         = pc;
    bus.upd_cmd_e    = cmd;
    bus.upd_pc_e     = upc;
    bus.upd_target_e = tgt;
    bus.br_valid_e   = bv;
    bus.br_taken_e   = bt;
    if (!r) model_reset();
    l_rst = r; l_cmd = cmd; l_upc = upc; l_tgt = tgt; l_bv = bv; l_bt = bt;
    exp_q.push_back(model_lookup(pc, name));
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    logic [31:0] i;
    t = 32'h10 + 32'($urandom_range(2, 0));
    i = 32'($urandom_range(3, 0));
    return (t << 8) | (i << 2);
  endfunction

  // Monitor: the lookup is presented every cycle; compare mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, ".taken"},  {31'd0, bus.pred_taken_f}, {31'd0, e.taken});
      check({e.name, ".target"}, bus.pred_target_f, e.target);
      check({e.name, ".br_cnt"}, bus.br_cnt, e.br);
      check({e.name, ".miss_cnt"}, bus.miss_cnt, e.miss);
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus.pc_f         = 32'h1004;
    bus.upd_cmd_e    = 2'b00;
    bus.upd_pc_e     = 32'd0;
    bus.upd_target_e = 32'd0;
    bus.br_valid_e   = 1'b0;
    bus.br_taken_e   = 1'b0;
    l_rst = 1'b0; l_cmd = 2'b00; l_upc = 32'd0; l_tgt = 32'd0; l_bv = 1'b0; l_bt = 1'b0;
    model_reset();

    cycle("in_reset",    1'b0, 32'h1004, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);
    cycle("released",    1'b1, 32'h1004, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);
    cycle("alloc_cyc",   1'b1, 32'h1004, 2'b10, 32'h1004, 32'h2000, 1'b1, 1'b1);
    cycle("alloc_hit",   1'b1, 32'h1004, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);
    cycle("alias_miss",  1'b1, 32'h1104, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);
    cycle("weaken",      1'b1, 32'h1004, 2'b01, 32'h1004, 32'd0,    1'b1, 1'b0);
    cycle("weak_look",   1'b1, 32'h1004, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);
    cycle("train",       1'b1, 32'h1004, 2'b00, 32'h1004, 32'd0,    1'b1, 1'b1);
    cycle("train_look",  1'b1, 32'h1004, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);
    cycle("realloc",     1'b1, 32'h1004, 2'b10, 32'h1004, 32'h3000, 1'b1, 1'b1);
    cycle("rbw_look",    1'b1, 32'h1004, 2'b10, 32'h1004, 32'h3000, 1'b1, 1'b1);
    cycle("new_target",  1'b1, 32'h1004, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);
    cycle("pc_wrap",     1'b1, 32'hFFFF_FFFC, 2'b11, 32'h1004, 32'h4000, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      cycle("random", 1'b1, rand_pc(), 2'($urandom_range(3, 0)), rand_pc(),
            32'($urandom) & 32'hFFFF_FFFC, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    cycle("pre_rst",     1'b1, 32'h1004, 2'b10, 32'h1004, 32'h5000, 1'b1, 1'b1);
    cycle("rst_mid",     1'b0, 32'h1004, 2'b10, 32'h1004, 32'h6000, 1'b1, 1'b1);
    cycle("rst_hold",    1'b0, 32'h1004, 2'b10, 32'h1004, 32'h6000, 1'b1, 1'b1);
    cycle("rst_release", 1'b1, 32'h1004, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);
    cycle("post_rel",    1'b1, 32'h1004, 2'b00, 32'd0,    32'd0,    1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
